// File: rtl/dual_slope_scan_sequencer.sv
// Dual-slope ADC scan sequencer.
// Steps through the enabled mux channels. For each channel it waits for the
// mux to settle, starts a conversion, captures the count and hands the result
// out over a valid/ready port.
// Optional feature macro: SCAN_AVG_EN. When defined, each result is the
// average of 4 conversions (sum >> 2, truncated).
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   scan_en, ch_mask       scan request level, per-channel enables
//   conv_start             one-cycle start pulse to the converter
//   conv_ld, conv_count    converter load pulse and its count
//   ch_sel                 analog mux select
//   busy                   high outside IDLE
//   res_valid, res_ready   result handshake
//   res_data, res_ch       result value and its channel
//   timeout_err            sticky conversion-timeout flag
module dual_slope_scan_sequencer #(
    parameter int unsigned CNT_W   = 12,
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scan_en,
    input  logic [3:0]       ch_mask,
    output logic             conv_start,
    input  logic             conv_ld,
    input  logic [CNT_W-1:0] conv_count,
    output logic [1:0]       ch_sel,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_data,
    output logic [1:0]       res_ch,
    output logic             timeout_err
);

    localparam int unsigned SET_W = 4;
    localparam int unsigned TMR_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        START,
        WAIT,
        OUTPUT,
        NEXT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [SET_W-1:0]   settle_cnt;
    logic [TMR_W-1:0]   wait_tmr;
    logic               settle_done;
    logic               tmr_expired;
    logic               last_conv;
    logic [CNT_W-1:0]   result;

    // First enabled channel strictly after cur, wrapping; returns cur itself
    // when it is the only enabled channel.
    function automatic logic [1:0] next_ch(input logic [3:0] mask, input logic [1:0] cur);
        logic [1:0] c;
        logic [1:0] r;
        logic       found;
        r     = cur;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            c = 2'(cur + 2'(i));
            if (!found && mask[c]) begin
                r     = c;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign settle_done = (settle_cnt == SET_W'(SETTLE - 1));
    // wait_tmr counts cycles since conv_start (1 in the first WAIT cycle)
    assign tmr_expired = (wait_tmr >= TMR_W'(TIMEOUT - 1));

`ifdef SCAN_AVG_EN
    logic [CNT_W+1:0] acc;
    logic [CNT_W+1:0] acc_sum;
    logic [1:0]       conv_idx;

    assign acc_sum   = acc + (CNT_W+2)'(conv_count);
    assign last_conv = (conv_idx == 2'd3);
    assign result    = acc_sum[CNT_W+1:2];

    // Accumulator: dropped on timeout, restarted after the fourth sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            conv_idx <= '0;
        end else if (state == WAIT) begin
            if (conv_ld) begin
                if (last_conv) begin
                    acc      <= '0;
                    conv_idx <= '0;
                end else begin
                    acc      <= acc_sum;
                    conv_idx <= conv_idx + 2'd1;
                end
            end else if (tmr_expired) begin
                acc      <= '0;
                conv_idx <= '0;
            end
        end
    end
`else
    assign last_conv = 1'b1;
    assign result    = conv_count;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (scan_en && (ch_mask != 4'd0)) state_nxt = SELECT;
            SELECT:  if (settle_done) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT: begin
                if (conv_ld)          state_nxt = last_conv ? OUTPUT : SELECT;
                else if (tmr_expired) state_nxt = NEXT;
            end
            OUTPUT:  if (res_ready) state_nxt = NEXT;
            NEXT:    state_nxt = (scan_en && (ch_mask != 4'd0)) ? SELECT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs, timers and channel/result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conv_start  <= 1'b0;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            timeout_err <= 1'b0;
            res_data    <= '0;
            res_ch      <= '0;
            ch_sel      <= '0;
            settle_cnt  <= '0;
            wait_tmr    <= '0;
        end else begin
            conv_start <= (state_nxt == START);
            busy       <= (state_nxt != IDLE);
            res_valid  <= (state_nxt == OUTPUT);
            settle_cnt <= (state == SELECT) ? settle_cnt + SET_W'(1) : '0;

            if (state == START)     wait_tmr <= TMR_W'(1);
            else if (state == WAIT) wait_tmr <= wait_tmr + TMR_W'(1);

            if (state == IDLE && state_nxt == SELECT) begin
                ch_sel      <= next_ch(ch_mask, 2'd3);
                timeout_err <= 1'b0;
            end else if (state == NEXT && state_nxt == SELECT) begin
                ch_sel <= next_ch(ch_mask, ch_sel);
            end

            if (state == WAIT) begin
                if (conv_ld) begin
                    if (last_conv) begin
                        res_data <= result;
                        res_ch   <= ch_sel;
                    end
                end else if (tmr_expired) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dual_slope_scan_sequencer.sv
// Directed bench for dual_slope_scan_sequencer with a result scoreboard.
module tb_dual_slope_scan_sequencer;

    localparam int unsigned CNT_W   = 12;
    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 50;
`ifdef SCAN_AVG_EN
    localparam int NCONV = 4;
`else
    localparam int NCONV = 1;
`endif

    typedef struct packed {
        logic [1:0]       ch;
        logic [CNT_W-1:0] data;
    } res_t;

    logic             clk;
    logic             rst;
    logic             scan_en;
    logic [3:0]       ch_mask;
    logic             conv_start;
    logic             conv_ld;
    logic [CNT_W-1:0] conv_count;
    logic [1:0]       ch_sel;
    logic             busy;
    logic             res_valid;
    logic             res_ready;
    logic [CNT_W-1:0] res_data;
    logic [1:0]       res_ch;
    logic             timeout_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_ld  = 0;
    res_t sb[$];

    dual_slope_scan_sequencer #(
        .CNT_W  (CNT_W),
        .SETTLE (SETTLE),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .scan_en    (scan_en),
        .ch_mask    (ch_mask),
        .conv_start (conv_start),
        .conv_ld    (conv_ld),
        .conv_count (conv_count),
        .ch_sel     (ch_sel),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_ch     (res_ch),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int off(input int k);
        case (k)
            0: return 0;
            1: return 1;
            2: return 2;
            default: return 5;
        endcase
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_conv_start"}, 32'(conv_start), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_res_valid"}, 32'(res_valid), 0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
        chk({tag, "_res_data"}, 32'(res_data), 0);
        chk({tag, "_res_ch"}, 32'(res_ch), 0);
        chk({tag, "_ch_sel"}, 32'(ch_sel), 0);
    endtask

    task automatic wait_start(output int sc);
        int n;
        n = 0;
        while (conv_start !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (conv_start !== 1'b1) chk("start_seen", 32'(conv_start), 1);
        sc = cyc;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("reach_idle", 32'(busy), 0);
    endtask

    // Serve one channel: NCONV conversions, scoreboard entry for the result
    task automatic run_channel(input logic [1:0] ch, input int base, input int dly,
                               input int exp_first, input bit drop_en);
        int   sc;
        int   sum;
        res_t e;
        sum = 0;
        for (int k = 0; k < NCONV; k++) begin
            wait_start(sc);
            chk("start_cycle", 32'(sc), 32'((k == 0) ? exp_first : last_ld + int'(SETTLE) + 1));
            chk("ch_sel", 32'(ch_sel), 32'(ch));
            sum += base + off(k);
            if (k == NCONV - 1) begin
                e.ch = ch;
`ifdef SCAN_AVG_EN
                e.data = CNT_W'(sum >> 2);
`else
                e.data = CNT_W'(sum);
`endif
                sb.push_back(e);
            end
            repeat (dly) @(negedge clk);
            if (drop_en && k == NCONV - 1) scan_en = 1'b0;
            conv_ld    = 1'b1;
            conv_count = CNT_W'(base + off(k));
            last_ld    = cyc;
            @(negedge clk);
            conv_ld = 1'b0;
        end
    endtask

    // Result monitor: checks transfers against the scoreboard and hold stability
    initial begin
        bit               prev_v;
        logic [CNT_W-1:0] hold_d;
        logic [1:0]       hold_c;
        res_t             e;
        prev_v = 1'b0;
        hold_d = '0;
        hold_c = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_v = 1'b0;
            end else begin
                if (res_valid) begin
                    chk("no_start_in_output", 32'(conv_start), 0);
                    if (prev_v) begin
                        chk("res_data_stable", 32'(res_data), 32'(hold_d));
                        chk("res_ch_stable", 32'(res_ch), 32'(hold_c));
                    end
                    hold_d = res_data;
                    hold_c = res_ch;
                    if (res_ready) begin
                        if (sb.size() == 0) begin
                            chk("spurious_result", 32'(res_valid), 0);
                        end else begin
                            e = sb.pop_front();
                            chk("res_ch", 32'(res_ch), 32'(e.ch));
                            chk("res_data", 32'(res_data), 32'(e.data));
                        end
                    end
                end
                prev_v = res_valid && !res_ready;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (observed running, expected done)");
        $fatal(1, "watchdog");
    end

    initial begin
        int en;
        int sc;
        int r;
        rst        = 1'b1;
        scan_en    = 1'b0;
        ch_mask    = 4'd0;
        conv_ld    = 1'b0;
        conv_count = '0;
        res_ready  = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // No channels enabled: never leaves IDLE
        scan_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("mask0_busy", 32'(busy), 0);
            chk("mask0_start", 32'(conv_start), 0);
        end

        // Channels 0 and 2, conversions 20 cycles after each start
        ch_mask = 4'b0101;
        en = cyc;
        run_channel(2'd0, 100, 20, en + int'(SETTLE) + 1, 1'b0);
        run_channel(2'd2, 200, 20, last_ld + int'(SETTLE) + 3, 1'b0);
        run_channel(2'd0, 300, 20, last_ld + int'(SETTLE) + 3, 1'b0);
        run_channel(2'd2, 400, 20, last_ld + int'(SETTLE) + 3, 1'b1);
        wait_idle();
        chk("scan02_drained", 32'(sb.size()), 0);

        // scan_en dropped during WAIT on channel 1: result still delivered
        ch_mask = 4'b0010;
        scan_en = 1'b1;
        en = cyc;
        run_channel(2'd1, 12'h7F0, 10, en + int'(SETTLE) + 1, 1'b1);
        wait_idle();
        chk("ch1_drained", 32'(sb.size()), 0);
        chk("ch1_idle_res_valid", 32'(res_valid), 0);

        // Timeout on channel 3, then the channel is restarted
        ch_mask = 4'b1000;
        scan_en = 1'b1;
        en = cyc;
        wait_start(sc);
        chk("to_start_cycle", 32'(sc), 32'(en + int'(SETTLE) + 1));
        repeat (TIMEOUT - 1) @(negedge clk);
        chk("to_before", 32'(timeout_err), 0);
        chk("to_before_busy", 32'(busy), 1);
        @(negedge clk);
        chk("to_at_limit", 32'(timeout_err), 1);
        chk("to_no_valid", 32'(res_valid), 0);
        run_channel(2'd3, 12'h0AA, 6, sc + int'(TIMEOUT) + int'(SETTLE) + 1, 1'b1);
        wait_idle();
        chk("to_sticky", 32'(timeout_err), 1);

        // timeout_err cleared on new scan; result held while res_ready is low
        ch_mask   = 4'b0100;
        scan_en   = 1'b1;
        res_ready = 1'b0;
        en = cyc;
        @(negedge clk);
        chk("to_cleared", 32'(timeout_err), 0);
        chk("scan_busy", 32'(busy), 1);
        run_channel(2'd2, 12'hABC, 5, en + int'(SETTLE) + 1, 1'b0);
        for (int i = 0; i < 30; i++) begin
            chk("hold_valid", 32'(res_valid), 1);
            @(negedge clk);
        end
        res_ready = 1'b1;
        r = cyc;
        run_channel(2'd2, 12'h123, 5, r + int'(SETTLE) + 2, 1'b1);
        wait_idle();
        chk("hold_drained", 32'(sb.size()), 0);

        // Reset during WAIT, then a late conv_ld is ignored
        ch_mask = 4'b1000;
        scan_en = 1'b1;
        wait_start(sc);
        repeat (5) @(negedge clk);
        chk("pre_rst_ch_sel", 32'(ch_sel), 3);
        scan_en = 1'b0;
        rst = 1'b1;
        #1;
        check_zero("rst_wait");
        @(negedge clk);
        rst        = 1'b0;
        conv_ld    = 1'b1;
        conv_count = 12'h777;
        @(negedge clk);
        conv_ld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("late_ld_busy", 32'(busy), 0);
            chk("late_ld_valid", 32'(res_valid), 0);
            chk("late_ld_data", 32'(res_data), 0);
            @(negedge clk);
        end

        // Reset during OUTPUT
        ch_mask   = 4'b0100;
        scan_en   = 1'b1;
        res_ready = 1'b0;
        en = cyc;
        run_channel(2'd2, 12'h321, 4, en + int'(SETTLE) + 1, 1'b1);
        chk("pre_rst_valid", 32'(res_valid), 1);
        rst = 1'b1;
        #1;
        check_zero("rst_output");
        sb.delete();
        @(negedge clk);
        rst     = 1'b0;
        conv_ld = 1'b1;
        @(negedge clk);
        conv_ld = 1'b0;
        @(negedge clk);
        chk("late_ld2_busy", 32'(busy), 0);
        chk("late_ld2_valid", 32'(res_valid), 0);

        // First state change on the next edge after scan_en rises
        ch_mask   = 4'b0001;
        scan_en   = 1'b1;
        res_ready = 1'b1;
        en = cyc;
        @(negedge clk);
        chk("restart_busy", 32'(busy), 1);
        run_channel(2'd0, 12'h0F0, 2, en + int'(SETTLE) + 1, 1'b1);
        wait_idle();
        chk("final_drained", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dual_slope_scan_sequencer.md
DUAL_SLOPE_SCAN_SEQUENCER -- requirements
Module: dual_slope_scan_sequencer

Interface
REQ-001 Parameter CNT_W, default 12: width of the conversion count and result data.
REQ-002 Parameter SETTLE, default 4: mux settling cycles between channel selection and conversion start (range 1..15).
REQ-003 Parameter TIMEOUT, default 4095: maximum cycles waited for conv_ld after conv_start (range 1..65535).
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 scan_en  input  1  level; high requests continuous scanning.
REQ-007 ch_mask  input  4  channel enables, bit i enables channel i.
REQ-008 conv_start  output  1  one-cycle start pulse to the conversion state machine.
REQ-009 conv_ld  input  1  load pulse from the conversion state machine; conv_count is valid in the same cycle.
REQ-010 conv_count  input  CNT_W  conversion result count.
REQ-011 ch_sel  output  2  analog input mux select.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 res_valid / res_ready  output / input  1 / 1  result handshake; transfer occurs when both are high on a rising edge.
REQ-014 res_data / res_ch  output  CNT_W / 2  result value and its channel; stable while res_valid is high.
REQ-015 timeout_err  output  1  sticky conversion-timeout flag.

Function
REQ-016 FSM states SHALL be IDLE, SELECT, START, WAIT, OUTPUT and NEXT.
REQ-017 IDLE -> SELECT when scan_en=1 and ch_mask!=0; ch_sel is loaded with the lowest enabled channel, and timeout_err is cleared on this transition.
REQ-018 With ch_mask=0, the block SHALL remain in IDLE with busy=0 regardless of scan_en.
REQ-019 SELECT SHALL last exactly SETTLE cycles and then go to START.
REQ-020 START SHALL assert conv_start for exactly one cycle, clear the WAIT timer, and go to WAIT.
REQ-021 In WAIT, conv_ld=1 SHALL capture conv_count; go to OUTPUT when the sample set is complete (REQ-029), otherwise go to SELECT.
REQ-022 In WAIT, if TIMEOUT cycles elapse without conv_ld, the block SHALL set timeout_err, discard any partial accumulation for that channel, and go to NEXT with no result.
REQ-023 conv_ld SHALL be ignored in every state other than WAIT.
REQ-024 OUTPUT SHALL hold res_valid=1 with constant res_data/res_ch until res_ready=1, then go to NEXT; res_ready already high on entry transfers on the first cycle.
REQ-025 NEXT SHALL sample ch_mask and scan_en. If scan_en=0 or ch_mask=0, go to IDLE. Otherwise select the next enabled channel above the current one, wrapping 3 -> lowest enabled, then go to SELECT.
REQ-026 A single enabled channel SHALL be reselected each pass.
REQ-027 Deasserting scan_en mid-scan SHALL NOT abort the scan; the current channel completes, including its handshake.
REQ-028 ch_mask changes SHALL take effect only in NEXT.
REQ-029 A sample set SHALL be 1 conversion, or 4 conversions when SCAN_AVG_EN is defined (REQ-035).
REQ-030 Latency from NEXT to conv_start SHALL be SETTLE+1 cycles.

Reset
REQ-031 On rst=1, the block SHALL asynchronously enter IDLE.
REQ-032 On rst=1, the block SHALL asynchronously clear conv_start, busy, res_valid, timeout_err, res_data, res_ch, ch_sel, the accumulator and all timers, including when rst is asserted mid-conversion or mid-handshake.
REQ-033 After rst is released, the first state change SHALL occur on the next rising clk edge with scan_en=1.

Configuration
REQ-034 Macro SCAN_AVG_EN SHALL select averaging.
REQ-035 With SCAN_AVG_EN defined, each channel SHALL take 4 conversions (SELECT->START->WAIT per conversion) summed in a CNT_W+2 accumulator, with res_data = sum>>2 (truncated).
REQ-036 With SCAN_AVG_EN undefined, res_data SHALL be the single captured conv_count and no accumulator SHALL be synthesized.

Verification
REQ-037 ch_mask=4'b0101, scan_en=1, conv_ld 20 cycles after each conv_start, res_ready=1 -> results appear in res_ch order 0,2,0,2, with conv_start spaced per REQ-030.
REQ-038 SCAN_AVG_EN defined, ch_mask=4'b0010, counts 100,101,102,105 -> res_data=102, res_ch=1.
REQ-039 ch_mask=4'b1000, conv_ld never asserted, TIMEOUT=50 -> timeout_err=1 at 50 cycles after conv_start, no res_valid, channel 3 restarted.
REQ-040 res_ready held low 30 cycles -> res_valid and res_data are stable for 30 cycles, with no conv_start until transfer plus NEXT.
REQ-041 scan_en dropped during WAIT on channel 1 -> channel 1 result delivered, then IDLE and busy=0.
REQ-042 rst pulsed during WAIT and again during OUTPUT -> all outputs 0 immediately, and a late conv_ld is ignored.
